// File: rtl/stream_width_downconv.sv
// Width down-converter: splits each IN_WIDTH input word into RATIO OUT_WIDTH
// sub-words, LSB first, with zero-bubble hand-off between consecutive words.
module stream_width_downconv #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [IN_WIDTH-1:0]  in0_V_TDATA,
    input  logic                 in0_V_TVALID,
    output logic                 in0_V_TREADY,
    output logic [OUT_WIDTH-1:0] out_V_TDATA,
    output logic                 out_V_TVALID,
    input  logic                 out_V_TREADY,
    output logic                 busy
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_param_err
        $error("stream_width_downconv: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
    end

    typedef enum logic {EMPTY, SHIFT} state_t;

    state_t                            state;
    logic [RATIO-1:0][OUT_WIDTH-1:0]   hold;
    logic [IDX_W-1:0]                  idx;
    logic                              last;
    logic                              in_xfer;
    logic                              out_xfer;

    assign last         = (idx == IDX_W'(RATIO - 1));
    // Ready on the final sub-word lets the next word load in the same edge.
    assign in0_V_TREADY = (state == EMPTY) || (last && out_V_TREADY);
    assign out_V_TVALID = (state == SHIFT);
    assign busy         = (state == SHIFT);
    assign out_V_TDATA  = hold[idx];
    assign in_xfer      = in0_V_TVALID && in0_V_TREADY;
    assign out_xfer     = out_V_TVALID && out_V_TREADY;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= EMPTY;
            idx   <= '0;
            hold  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        hold  <= in0_V_TDATA;
                        idx   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_xfer) begin
                        if (!last) begin
                            idx <= idx + IDX_W'(1);
                        end else if (in_xfer) begin
                            hold <= in0_V_TDATA;
                            idx  <= '0;
                        end else begin
                            idx   <= '0;
                            state <= EMPTY;
                        end
                    end
                end
                default: begin
                    state <= EMPTY;
                    idx   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stream_width_downconv.sv
// Bench for stream_width_downconv: directed corner sequences plus a table of
// words streamed under random backpressure, checked through a byte scoreboard.
module tb_stream_width_downconv;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];
    logic [7:0] cur_exp[4];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  e[4];
    } vec_t;

    vec_t tbl[6];

    logic [7:0] w1e[4];
    logic [7:0] w2e[4];
    logic [7:0] b2b[8];

    stream_width_downconv #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .in0_V_TDATA  (in_data),
        .in0_V_TVALID (in_valid),
        .in0_V_TREADY (in_ready),
        .out_V_TDATA  (out_data),
        .out_V_TVALID (out_valid),
        .out_V_TREADY (out_ready),
        .busy         (busy)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] e[4]);
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 4; k++) cur_exp[k] = e[k];
    endtask

    // Inputs change 1 time unit after posedge, so mid-cycle values are what the next edge sees.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got %0h want none", out_data);
                end else begin
                    check("sb_data", {24'h0, out_data}, {24'h0, sb.pop_front()});
                end
            end
            if (in_valid && in_ready)
                for (int k = 0; k < 4; k++) sb.push_back(cur_exp[k]);
        end
    end

    always @(negedge ap_rst_n) sb.delete();

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   guard;

        w1e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        w2e = '{8'h11, 8'h22, 8'h33, 8'h44};
        b2b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        tbl[0] = '{32'hDDCCBBAA, '{8'hAA, 8'hBB, 8'hCC, 8'hDD}};
        tbl[1] = '{32'h44332211, '{8'h11, 8'h22, 8'h33, 8'h44}};
        tbl[2] = '{32'h00000000, '{8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[3] = '{32'hFFFFFFFF, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        tbl[4] = '{32'h80000001, '{8'h01, 8'h00, 8'h00, 8'h80}};
        tbl[5] = '{32'h12345678, '{8'h78, 8'h56, 8'h34, 8'h12}};

        in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cur_exp[k] = 8'h00;

        // Asynchronous reset asserted mid-cycle.
        repeat (2) @(posedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);

        // Single word, offered together with reset release.
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        send(32'hDDCCBBAA, w1e);
        @(posedge ap_clk); #1 in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge ap_clk);
            check("single_valid", out_valid, 1);
            check("single_data", out_data, w1e[k]);
            check("single_inready", in_ready, (k == 3));
        end
        @(negedge ap_clk);
        check("drain_valid", out_valid, 0);
        check("drain_busy", busy, 0);
        check("drain_inready", in_ready, 1);

        // Back-to-back words with valid held high.
        @(posedge ap_clk); #1 send(32'hDDCCBBAA, w1e);
        @(posedge ap_clk); #1 send(32'h44332211, w2e);
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            check("b2b_valid", out_valid, 1);
            check("b2b_data", out_data, b2b[k]);
            check("b2b_inready", in_ready, (k % 4 == 3));
            if (k == 3) begin
                @(posedge ap_clk); #1 in_valid = 1'b0;
            end
        end
        @(negedge ap_clk);
        check("b2b_drain", out_valid, 0);

        // Backpressure while 0xBB is presented.
        @(posedge ap_clk); #1 send(32'hDDCCBBAA, w1e);
        @(posedge ap_clk); #1 in_valid = 1'b0;
        @(negedge ap_clk);
        check("bp_first", out_data, 8'hAA);
        @(posedge ap_clk); #1 out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge ap_clk);
            check("bp_hold_data", out_data, 8'hBB);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_inready", in_ready, 0);
            @(posedge ap_clk); #1;
        end
        out_ready = 1'b1;
        @(negedge ap_clk); check("bp_release", out_data, 8'hBB);
        @(negedge ap_clk); check("bp_next", out_data, 8'hCC);
        @(negedge ap_clk); check("bp_last", out_data, 8'hDD);
        @(negedge ap_clk); check("bp_drain", out_valid, 0);

        // Reset in the middle of a word.
        @(posedge ap_clk); #1 send(32'hDDCCBBAA, w1e);
        @(posedge ap_clk); #1 in_valid = 1'b0;
        @(negedge ap_clk); check("mid_first", out_data, 8'hAA);
        @(posedge ap_clk); #2 ap_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_ready", in_ready, 1);
        @(posedge ap_clk); #1 ap_rst_n = 1'b1;
        send(32'h44332211, w2e);
        @(posedge ap_clk); #1 in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge ap_clk);
            check("mid_valid", out_valid, 1);
            check("mid_data", out_data, w2e[k]);
        end
        @(negedge ap_clk); check("mid_drain", out_valid, 0);

        // Table of words streamed under random output backpressure.
        @(posedge ap_clk); #1;
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].data, tbl[i].e);
            guard = 0;
            do begin
                @(negedge ap_clk);
                acc = in_ready;
                @(posedge ap_clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
                guard++;
            end while (!acc && guard < 200);
            if (!acc) check("tbl_accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 200) begin
            @(posedge ap_clk); #1;
            guard++;
        end
        @(negedge ap_clk);
        check("tbl_sb_empty", sb.size(), 0);
        check("tbl_end_valid", out_valid, 0);
        check("tbl_end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
